// File: rtl/regfile_scoreboard_pkg.sv
// Shared core definitions for the register file with load scoreboard:
// default geometry and the reset-value encoding.
package regfile_scoreboard_pkg;

  localparam int unsigned RF_XLEN_DEF  = 64;
  localparam int unsigned RF_NREGS_DEF = 32;

  // INIT_INDEX encoding
  localparam int unsigned RF_INIT_ZERO  = 0;
  localparam int unsigned RF_INIT_INDEX = 1;

  // Reset word for register idx; register 0 is always zero.
  function automatic logic [63:0] rf_reset_word(input int unsigned idx,
                                                input int unsigned mode);
    logic [63:0] v;
    v = '0;
    if (mode != RF_INIT_ZERO && idx != 0) begin
      v = 64'(idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/sb_pending.sv
// Load scoreboard: one pending bit per register plus a registered
// population count of the bitmap.
module sb_pending
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_addr,
  input  logic             i_clr_en,
  input  logic [AW-1:0]    i_clr_addr,
  output logic [NREGS-1:0] o_pending,
  output logic [AW:0]      o_pend_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [NREGS-1:0] r_pend;
  logic [CW-1:0]    r_cnt;
  logic [NREGS-1:0] w_pend_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  // Clear from load writeback first so a same-cycle issue wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr_en && i_clr_addr != '0) begin
      w_pend_nxt[i_clr_addr] = 1'b0;
    end
    if (i_iss_en && i_iss_addr != '0) begin
      w_pend_nxt[i_iss_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_pending  = r_pend;
  assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with write-to-read bypass and a
// load scoreboard reporting per-register busy and total pending count.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN       = RF_XLEN_DEF,
  parameter int unsigned NREGS      = RF_NREGS_DEF,
  parameter int unsigned INIT_INDEX = RF_INIT_INDEX,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wa_en,
  input  logic [AW-1:0]   wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wl_en,
  input  logic [AW-1:0]   wl_addr,
  input  logic [XLEN-1:0] wl_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic [AW:0]     pend_cnt,
  output logic            collide
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic             r_collide;
  logic             w_wa_ok;
  logic             w_wl_ok;
  logic [NREGS-1:0] w_pending;
  logic [XLEN-1:0]  w_rs1_data;
  logic [XLEN-1:0]  w_rs2_data;

  assign w_wa_ok = wa_en && (wa_addr != '0);
  assign w_wl_ok = wl_en && (wl_addr != '0);

  // Port L is written last so it overrides port A on an address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= XLEN'(rf_reset_word(i, INIT_INDEX));
      end
    end else begin
      if (w_wa_ok) begin
        r_regs[wa_addr] <= wa_data;
      end
      if (w_wl_ok) begin
        r_regs[wl_addr] <= wl_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_collide <= 1'b0;
    end else begin
      r_collide <= w_wa_ok && w_wl_ok && (wa_addr == wl_addr);
    end
  end

  // Read muxes: stored value, then A bypass, then L bypass (highest priority).
  always_comb begin
    w_rs1_data = r_regs[rs1_addr];
    if (w_wa_ok && wa_addr == rs1_addr) begin
      w_rs1_data = wa_data;
    end
    if (w_wl_ok && wl_addr == rs1_addr) begin
      w_rs1_data = wl_data;
    end
    if (rs1_addr == '0) begin
      w_rs1_data = '0;
    end
  end

  always_comb begin
    w_rs2_data = r_regs[rs2_addr];
    if (w_wa_ok && wa_addr == rs2_addr) begin
      w_rs2_data = wa_data;
    end
    if (w_wl_ok && wl_addr == rs2_addr) begin
      w_rs2_data = wl_data;
    end
    if (rs2_addr == '0) begin
      w_rs2_data = '0;
    end
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;

  // A load landing this cycle already supplies its data, so it is not busy.
  assign rs1_busy = w_pending[rs1_addr] && !(w_wl_ok && wl_addr == rs1_addr);
  assign rs2_busy = w_pending[rs2_addr] && !(w_wl_ok && wl_addr == rs2_addr);
  assign collide  = r_collide;

  sb_pending #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb_pending (
    .clk        (clk),
    .reset      (reset),
    .i_iss_en   (iss_en),
    .i_iss_addr (iss_addr),
    .i_clr_en   (wl_en),
    .i_clr_addr (wl_addr),
    .o_pending  (w_pending),
    .o_pend_cnt (pend_cnt)
  );

endmodule
